// File: rtl/sprite_fetch_arbiter_if.sv
// Bus bundle between the pixel-fetch requesters, the sprite fetch arbiter and the sprite ROM.
interface sprite_fetch_arbiter_if #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH-1:0]        gnt;
  logic                     flush;
  logic                     rom_en;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     rtransparent;
  logic                     busy;

  // Arbiter side of the bundle.
  modport slave (
    input  req, addr, flush, rom_data,
    output gnt, rom_en, rom_addr, rvalid, rdata, rtransparent, busy
  );

  // Requester and ROM side of the bundle.
  modport master (
    output req, addr, flush, rom_data,
    input  gnt, rom_en, rom_addr, rvalid, rdata, rtransparent, busy
  );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one registered sprite ROM read port among NUM_CH pixel fetchers.
// A tag pipeline matched to the ROM latency routes each returned word back to its requester.
module sprite_fetch_arbiter #(
  parameter int                NUM_CH          = 6,
  parameter int                ADDR_W          = 16,
  parameter int                DATA_W          = 12,
  parameter int                ROM_LATENCY     = 1,
  parameter logic [DATA_W-1:0] TRANSPARENT_KEY = 'hF0F
) (
  input logic                   clk,
  input logic                   rst,
  sprite_fetch_arbiter_if.slave bus
);
  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              STAGES  = ROM_LATENCY + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   ptr;
  logic              grant_any;
  logic [CH_W-1:0]   grant_ch;
  logic [NUM_CH-1:0] grant_vec;
  logic [ADDR_W-1:0] sel_addr;
  logic [STAGES-1:0] tag_valid;
  logic [CH_W-1:0]   tag_ch [STAGES];
  logic [NUM_CH-1:0] ret_onehot;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [NUM_CH-1:0] rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rtransparent_q;

  // Search for the first requester after the last winner; reset and flush block every grant.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_ch  = ptr;
    grant_vec = '0;
    if (!rst && !bus.flush) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = (int'(ptr) + k) % NUM_CH;
        if (!grant_any && bus.req[CH_W'(cand)]) begin
          grant_any = 1'b1;
          grant_ch  = CH_W'(cand);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      grant_vec[i] = grant_any && (grant_ch == CH_W'(i));
    end
  end

  // Pick the winning channel's address and decode the tag leaving the pipeline into a strobe.
  always_comb begin
    sel_addr   = '0;
    ret_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_vec[i]) begin
        sel_addr = bus.addr[ADDR_W*i +: ADDR_W];
      end
      ret_onehot[i] = (tag_ch[STAGES-1] == CH_W'(i));
    end
  end

  // Register the ROM request, shift the tags along with the ROM latency and capture returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= LAST_CH;
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      tag_valid      <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_ch[s] <= '0;
      end
      rvalid_q       <= '0;
      rdata_q        <= '0;
      rtransparent_q <= 1'b0;
    end else begin
      rom_en_q <= grant_any;
      if (grant_any) begin
        rom_addr_q <= sel_addr;
        ptr        <= grant_ch;
      end
      tag_valid[0] <= grant_any;
      tag_ch[0]    <= grant_ch;
      for (int s = 1; s < STAGES; s++) begin
        tag_valid[s] <= tag_valid[s-1] && !bus.flush;
        tag_ch[s]    <= tag_ch[s-1];
      end
      if (tag_valid[STAGES-1] && !bus.flush) begin
        rvalid_q       <= ret_onehot;
        rdata_q        <= bus.rom_data;
        rtransparent_q <= (bus.rom_data == TRANSPARENT_KEY);
      end else begin
        rvalid_q       <= '0;
        rtransparent_q <= 1'b0;
      end
    end
  end

  assign bus.gnt          = grant_vec;
  assign bus.rom_en       = rom_en_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = rdata_q;
  assign bus.rtransparent = rtransparent_q;
  assign bus.busy         = |tag_valid;
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench for sprite_fetch_arbiter: directed scenarios followed by randomized traffic.
module tb_sprite_fetch_arbiter;
  localparam int          NUM_CH      = 6;
  localparam int          ADDR_W      = 16;
  localparam int          DATA_W      = 12;
  localparam int          ROM_LATENCY = 1;
  localparam int          RET_DELAY   = ROM_LATENCY + 2;
  localparam logic [11:0] KEY         = 12'hF0F;

  typedef struct {
    int          ch;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  exp_t sb[$];

  // Reference model state
  bit          model_valid = 0;
  bit          after_rst = 0;
  bit          prev_rst = 0;
  bit          prev_flush = 0;
  bit          prev_grant = 0;
  logic [15:0] prev_addr = '0;
  int          ptr_m = NUM_CH - 1;
  int          cur_exp_ch = -1;
  logic        exp_rom_en = 1'b0;
  logic [15:0] exp_rom_addr = '0;

  sprite_fetch_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_fetch_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ROM_LATENCY(ROM_LATENCY), .TRANSPARENT_KEY(KEY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: mostly a[11:0], with a few directed words.
  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0123: return 12'hABC;
      16'h0040: return 12'hF0F;
      16'h0041: return 12'hF0E;
      default:  return a[11:0];
    endcase
  endfunction

  // Single-cycle synchronous ROM
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CH*ADDR_W-1:0] stepAddrs(input int base, input int step);
    logic [NUM_CH*ADDR_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[ADDR_W*i +: ADDR_W] = 16'(base + step * i);
    return v;
  endfunction

  task automatic applyStimulus(input logic [NUM_CH-1:0] r, input logic [NUM_CH*ADDR_W-1:0] a,
                               input logic f, input logic rs);
    @(posedge clk);
    #1;
    if (prev_rst) begin
      sb.delete();
      ptr_m        = NUM_CH - 1;
      exp_rom_en   = 1'b0;
      exp_rom_addr = '0;
      model_valid  = 1;
      after_rst    = 1;
    end else begin
      after_rst = 0;
      if (prev_flush) sb.delete();
      exp_rom_en = prev_grant;
      if (prev_grant) exp_rom_addr = prev_addr;
    end
    bus.req   = r;
    bus.addr  = a;
    bus.flush = f;
    rst       = rs;
    cur_exp_ch = -1;
    if (!rs && !f && model_valid) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (cur_exp_ch < 0 && r[(ptr_m + k) % NUM_CH]) cur_exp_ch = (ptr_m + k) % NUM_CH;
      end
    end
    prev_grant = (cur_exp_ch >= 0);
    if (prev_grant) begin
      ptr_m     = cur_exp_ch;
      prev_addr = a[ADDR_W*cur_exp_ch +: ADDR_W];
      sb.push_back('{ch: cur_exp_ch, data: rom_fn(prev_addr), cyc: cyc});
    end
    prev_flush = f;
    prev_rst   = rs;
  endtask

  task automatic checkOutput();
    logic busy_exp;
    @(negedge clk);
    if (!model_valid) return;
    busy_exp = 1'b0;
    foreach (sb[j]) begin
      if (cyc - sb[j].cyc >= 1 && cyc - sb[j].cyc <= RET_DELAY - 1) busy_exp = 1'b1;
    end
    checkValue("gnt", 32'(bus.gnt), (cur_exp_ch < 0) ? 32'd0 : (32'd1 << cur_exp_ch));
    checkValue("rom_en", 32'(bus.rom_en), 32'(exp_rom_en));
    checkValue("rom_addr", 32'(bus.rom_addr), 32'(exp_rom_addr));
    checkValue("busy", 32'(bus.busy), 32'(busy_exp));
    if (after_rst) begin
      checkValue("rst_rvalid", 32'(bus.rvalid), 32'd0);
      checkValue("rst_rdata", 32'(bus.rdata), 32'd0);
      checkValue("rst_rtransparent", 32'(bus.rtransparent), 32'd0);
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] r, input logic [NUM_CH*ADDR_W-1:0] a,
                      input logic f, input logic rs);
    applyStimulus(r, a, f, rs);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever a return strobe appears and flags late or missing returns.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        if (bus.rvalid != '0) begin
          if (sb.size() == 0) begin
            checkValue("spurious_rvalid", 32'(bus.rvalid), 32'd0);
          end else begin
            e = sb.pop_front();
            checkValue("rvalid", 32'(bus.rvalid), 32'd1 << e.ch);
            checkValue("rdata", 32'(bus.rdata), 32'(e.data));
            checkValue("rtransparent", 32'(bus.rtransparent), 32'(e.data == KEY));
            checkValue("latency", 32'(cyc - e.cyc), 32'(RET_DELAY));
          end
        end else begin
          checkValue("rtransparent_idle", 32'(bus.rtransparent), 32'd0);
          if (sb.size() > 0 && cyc - sb[0].cyc >= RET_DELAY) begin
            e = sb.pop_front();
            checkValue("missing_return", 32'(bus.rvalid), 32'd1 << e.ch);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NUM_CH-1:0]        r;
    logic [NUM_CH*ADDR_W-1:0] a;
    int                       sel;
    bus.req   = '0;
    bus.addr  = '0;
    bus.flush = 1'b0;
    bus.rom_data = '0;

    // Power-on reset and idle reset values
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    idle(2);

    // Single fetch on CR1
    step(6'b000100, stepAddrs(16'h0123, 0), 1'b0, 1'b0);
    idle(4);

    // Saturation from a fresh pointer
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(6'b111111, stepAddrs(0, 16'h0100), 1'b0, 1'b0);
    idle(4);

    // Round-robin resumes after the last winner
    step('0, '0, 1'b0, 1'b1);
    step(6'b001000, stepAddrs(16'h0200, 1), 1'b0, 1'b0);
    step(6'b010010, stepAddrs(16'h0300, 1), 1'b0, 1'b0);
    step(6'b010010, stepAddrs(16'h0400, 1), 1'b0, 1'b0);
    idle(4);

    // Flush discards two in-flight fetches and blocks a competing request
    step(6'b000011, stepAddrs(16'h0500, 1), 1'b0, 1'b0);
    step(6'b000011, stepAddrs(16'h0600, 1), 1'b0, 1'b0);
    step(6'b000001, stepAddrs(16'h0700, 1), 1'b1, 1'b0);
    idle(4);

    // Reset mid-flight, then all channels requesting: channel 0 wins first
    step(6'b000011, stepAddrs(16'h0800, 1), 1'b0, 1'b0);
    step(6'b000011, stepAddrs(16'h0900, 1), 1'b0, 1'b0);
    step(6'b111111, stepAddrs(16'h0A00, 1), 1'b0, 1'b1);
    step(6'b111111, stepAddrs(16'h0B00, 1), 1'b0, 1'b0);
    step(6'b111111, stepAddrs(16'h0C00, 1), 1'b0, 1'b0);
    idle(4);

    // Transparency key on CR4, followed by a near-miss colour
    step(6'b100000, stepAddrs(16'h0040, 0), 1'b0, 1'b0);
    step(6'b100000, stepAddrs(16'h0041, 0), 1'b0, 1'b0);
    idle(4);

    // Top-of-range address passes through unchanged
    step(6'b000001, stepAddrs(16'hFFFF, 0), 1'b0, 1'b0);
    idle(4);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      r = NUM_CH'($urandom_range(0, 63));
      for (int i = 0; i < NUM_CH; i++) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0:       a[ADDR_W*i +: ADDR_W] = 16'hFFFF;
          1:       a[ADDR_W*i +: ADDR_W] = 16'h0F0F;
          2:       a[ADDR_W*i +: ADDR_W] = 16'h0040;
          default: a[ADDR_W*i +: ADDR_W] = 16'($urandom);
        endcase
      end
      step(r, a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    idle(6);
    checkValue("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

Time-multiplexes one synchronous, single-read-port sprite ROM (12-bit RGB444 words, 16-bit address) among six pixel-fetch requesters: layer channels L1 and L2, and four character/sprite channels CR1 to CR4. The block replaces six combinational read ports with one registered port. It uses round-robin arbitration, a latency-matched tag pipeline and per-channel return strobes. It sits between the video layer generators and the sprite ROM.

## Interface
Parameters:
- NUM_CH, 6, number of requesters; channel map is 0=L1, 1=L2, 2..5=CR1..CR4.
- ADDR_W, 16, ROM address width.
- DATA_W, 12, ROM word width: R[11:8], G[7:4], B[3:0].
- ROM_LATENCY, 1, cycles from rom_addr/rom_en presented to rom_data valid; legal range 1..4.
- TRANSPARENT_KEY, 12'hF0F, colour value that flags a transparent pixel.

Ports:
- clk, in, 1, single clock; all state is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- req, in, NUM_CH, per-channel fetch request (level).
- addr, in, NUM_CH*ADDR_W, channel i address at [ADDR_W*i +: ADDR_W].
- gnt, out, NUM_CH, combinational one-hot grant; the address is accepted at the end of this cycle.
- flush, in, 1, discards all in-flight fetches and suppresses grants this cycle.
- rom_en, out, 1, registered ROM read enable.
- rom_addr, out, ADDR_W, registered ROM address.
- rom_data, in, DATA_W, ROM read data.
- rvalid, out, NUM_CH, registered one-hot return strobe.
- rdata, out, DATA_W, registered return pixel, shared by all channels.
- rtransparent, out, 1, registered; 1 when rdata == TRANSPARENT_KEY and rvalid is nonzero.
- busy, out, 1, 1 while any fetch is in flight (issued, not yet returned).

## Operation
- **Arbitration**
  - Round-robin over req. The search starts at (ptr+1) mod NUM_CH, where ptr is the last granted channel.
  - At most one grant per cycle.
  - ptr updates only on a grant. After reset ptr = NUM_CH-1, so channel 0 wins first.
- **Grant cycle** (gnt[i]=1):
  - rom_addr <= addr[i], rom_en <= 1.
  - Tag {valid, i} enters the tag pipeline.
  - The requester may change addr and req in the following cycle.
  - req held high is treated as a new request every cycle.
- **Idle:** with no grant, rom_en <= 0 and rom_addr holds its last value.
- **Tag pipeline:** ROM_LATENCY+1 stages of shift register. When a valid tag reaches the end:
  - rdata <= rom_data, rvalid[tag] <= 1, rtransparent <= (rom_data == TRANSPARENT_KEY).
  - Otherwise rvalid <= 0, rtransparent <= 0, and rdata holds.
- **Ordering:** returns come back in issue order. Fully pipelined: one fetch per cycle sustained.
- **flush:**
  - gnt = 0 that cycle.
  - All tag valid bits clear on the edge; data already registered in rdata/rvalid this edge is also suppressed.
  - ptr is unchanged. rom_en <= 0.
- **busy:** OR of all tag-pipeline valid bits.
- **Illegal input:** req with an address beyond ROM depth is not checked; the address is passed through.

## Timing
- **Reset values:** gnt=0 (forced while rst=1), rom_en=0, rom_addr=0, rvalid=0, rdata=0, rtransparent=0, busy=0, ptr=NUM_CH-1, all tags invalid.
- **Latency:** grant in cycle T → rom_addr/rom_en in T+1 → rom_data in T+1+ROM_LATENCY → rvalid/rdata in T+2+ROM_LATENCY (T+3 at the default).
- **rvalid:** exactly one cycle per grant; never two bits set at once.
- **Fairness:** a continuously requesting channel is granted within NUM_CH cycles.
- **Simultaneous flush and req:** flush wins; no grant, no ptr change.
- **Reset mid-operation:** all in-flight fetches are lost and no rvalid follows. The first grant after rst is released can occur in the first cycle with rst=0.
- **Wrap-around:**
  - ptr = NUM_CH-1 wraps to 0.
  - rom_addr 16'hFFFF is passed through unmodified.

## Test plan
1. **Single fetch:** ROM[0x0123]=0xABC; req[2]=1 with addr 0x0123 for one cycle T → gnt[2]=1 in T; rom_addr=0x0123, rom_en=1 in T+1; rvalid=6'b000100, rdata=0xABC in T+3 for one cycle; busy=1 in T+1..T+2.
2. **Saturation:** all req=1 for 12 cycles, ROM[a]=a[11:0], channel i address = 0x100*i → grants 0,1,2,3,4,5,0,… one per cycle; rvalid follows the same order 3 cycles later with rdata 0x000, 0x100, …, 0x500.
3. **Round-robin:** ch3 granted in T; in T+1 req=6'b010010 → gnt[4] in T+1, gnt[1] in T+2.
4. **Flush:** grants in T and T+1, flush=1 in T+2 with req[0]=1 → gnt=0 in T+2; no rvalid in T+3..T+5; busy=0 from T+3.
5. **Reset mid-flight:** two grants, then rst=1 for one cycle → all outputs at reset values, no rvalid afterwards; with req=6'b111111 the first grant after reset is ch0.
6. **Transparency:** ROM[0x0040]=0xF0F, ROM[0x0041]=0xF0E, back-to-back fetches on ch5 → rtransparent = 1 then 0, aligned with rvalid[5].
